// File: rtl/loader_pkg.sv
// Shared definitions for the program loader: default widths, depth and FSM state type.
package loader_pkg;

  localparam int unsigned DW       = 8;
  localparam int unsigned AW       = 4;
  localparam int unsigned LD_DEPTH = 16;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CHECK,
    DONE,
    ERR
  } ld_state_t;

endpackage

// File: rtl/prog_loader_if.sv
// Byte-wide valid/ready stream from the host into the program loader.
interface prog_loader_if #(
  parameter int unsigned DW = loader_pkg::DW
) ();

  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;

  modport master (output in_data, output in_valid, input  in_ready);
  modport slave  (input  in_data, input  in_valid, output in_ready);

endinterface

// File: rtl/prog_loader_ram.sv
// 2^AW x DW program memory: synchronous write, asynchronous read, no reset.
module prog_ram #(
  parameter int unsigned DW = loader_pkg::DW,
  parameter int unsigned AW = loader_pkg::AW
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/prog_loader.sv
// Program loader: streams 16 bytes plus checksum into program RAM and holds the
// CPU until a verified image is resident.
module prog_loader #(
  parameter int unsigned DW = loader_pkg::DW,
  parameter int unsigned AW = loader_pkg::AW
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          start,
  prog_loader_if.slave  bus,
  input  logic [AW-1:0] cpu_addr,
  output logic [DW-1:0] cpu_data,
  output logic          cpu_hold,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] sum
);

  import loader_pkg::*;

  ld_state_t     state;
  logic          ready_q;
  logic          hs;
  logic          we;
  logic [DW-1:0] next_sum;

  assign bus.in_ready = ready_q;

  always_comb begin
    hs       = bus.in_valid & ready_q;
    we       = hs && (state == LOAD);
    next_sum = sum + bus.in_data;
  end

  // Outputs are registered alongside the state so each is a pure function of it.
  always_ff @(posedge clk) begin
    if (!clr) begin
      state    <= IDLE;
      wr_addr  <= '0;
      sum      <= '0;
      ready_q  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      cpu_hold <= 1'b1;
    end else begin
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state    <= LOAD;
            wr_addr  <= '0;
            sum      <= '0;
            ready_q  <= 1'b1;
            busy     <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
            cpu_hold <= 1'b1;
          end
        end
        LOAD: begin
          if (hs) begin
            sum     <= next_sum;
            wr_addr <= wr_addr + 1'b1;
            if (wr_addr == AW'(LD_DEPTH - 1)) state <= CHECK;
          end
        end
        CHECK: begin
          if (hs) begin
            sum     <= next_sum;
            ready_q <= 1'b0;
            busy    <= 1'b0;
            if (next_sum == '0) begin
              state    <= DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state <= ERR;
              err   <= 1'b1;
            end
          end
        end
        default: begin
          state    <= IDLE;
          ready_q  <= 1'b0;
          busy     <= 1'b0;
          cpu_hold <= 1'b1;
        end
      endcase
    end
  end

  prog_ram #(.DW(DW), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (wr_addr),
    .wdata (bus.in_data),
    .raddr (cpu_addr),
    .rdata (cpu_data)
  );

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader.
module tb_prog_loader;

  logic       clk = 1'b0;
  logic       clr;
  logic       start;
  logic [3:0] cpu_addr;
  logic [7:0] cpu_data;
  logic       cpu_hold, busy, done, err;
  logic [3:0] wr_addr;
  logic [7:0] sum;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] img [16] = '{8'h09, 8'h1a, 8'h2b, 8'hec, 8'he0, 8'hf0, 8'hf0, 8'h00,
                           8'h00, 8'h10, 8'h14, 8'h18, 8'h20, 8'h00, 8'h00, 8'h00};

  prog_loader_if #(.DW(8)) bus ();

  prog_loader #(.DW(8), .AW(4)) dut (
    .clk      (clk),
    .clr      (clr),
    .start    (start),
    .bus      (bus.slave),
    .cpu_addr (cpu_addr),
    .cpu_data (cpu_data),
    .cpu_hold (cpu_hold),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .wr_addr  (wr_addr),
    .sum      (sum)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Offer one byte until accepted; in_ready seen now is what the next edge uses.
  task automatic send_byte(input logic [7:0] b);
    logic ok;
    ok = 1'b0;
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    for (int n = 0; n < 8 && !ok; n++) begin
      ok = (bus.in_ready === 1'b1);
      tick();
    end
    bus.in_valid = 1'b0;
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: byte %h not accepted, in_ready=%b want 1", b, bus.in_ready);
    end
  endtask

  task automatic test_reset();
    clr = 1'b0;
    tick();
    tick();
    clr = 1'b1;
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", bus.in_ready); end
    n_checks++; if (cpu_hold !== 1'b1) begin n_fail++; $display("FAIL reset_hold: got %b want 1", cpu_hold); end
    n_checks++; if (done !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL reset_flags: done=%b err=%b want 0 0", done, err); end
    n_checks++; if (wr_addr !== 4'd0 || sum !== 8'h00) begin n_fail++; $display("FAIL reset_ctr: wr_addr=%h sum=%h want 0 00", wr_addr, sum); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
  endtask

  task automatic test_good_load();
    cpu_addr = 4'd0;
    pulse_start();
    n_checks++; if (bus.in_ready !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL good_enter: ready=%b busy=%b want 1 1", bus.in_ready, busy); end
    send_byte(img[0]);
    n_checks++; if (cpu_data !== 8'h09) begin n_fail++; $display("FAIL good_zero_latency: got %h want 09", cpu_data); end
    n_checks++; if (wr_addr !== 4'd1) begin n_fail++; $display("FAIL good_addr1: got %h want 1", wr_addr); end
    for (int i = 1; i < 16; i++) send_byte(img[i]);
    n_checks++; if (sum !== 8'h56) begin n_fail++; $display("FAIL good_sum_pre: got %h want 56", sum); end
    n_checks++; if (wr_addr !== 4'd0 || done !== 1'b0 || cpu_hold !== 1'b1) begin n_fail++; $display("FAIL good_pre_check: wr_addr=%h done=%b hold=%b want 0 0 1", wr_addr, done, cpu_hold); end
    send_byte(8'haa);
    n_checks++; if (done !== 1'b1 || cpu_hold !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL good_done: done=%b hold=%b err=%b want 1 0 0", done, cpu_hold, err); end
    n_checks++; if (sum !== 8'h00) begin n_fail++; $display("FAIL good_sum_post: got %h want 00", sum); end
    n_checks++; if (bus.in_ready !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL good_idle_port: ready=%b busy=%b want 0 0", bus.in_ready, busy); end
    cpu_addr = 4'd3; #1;
    n_checks++; if (cpu_data !== 8'hec) begin n_fail++; $display("FAIL good_read3: got %h want ec", cpu_data); end
    cpu_addr = 4'd12; #1;
    n_checks++; if (cpu_data !== 8'h20) begin n_fail++; $display("FAIL good_read12: got %h want 20", cpu_data); end
  endtask

  task automatic test_bad_checksum();
    pulse_start();
    n_checks++; if (done !== 1'b0 || cpu_hold !== 1'b1 || wr_addr !== 4'd0) begin n_fail++; $display("FAIL bad_enter: done=%b hold=%b wr_addr=%h want 0 1 0", done, cpu_hold, wr_addr); end
    for (int i = 0; i < 16; i++) send_byte(img[i]);
    send_byte(8'hab);
    n_checks++; if (err !== 1'b1 || done !== 1'b0 || cpu_hold !== 1'b1) begin n_fail++; $display("FAIL bad_err: err=%b done=%b hold=%b want 1 0 1", err, done, cpu_hold); end
    n_checks++; if (sum !== 8'h01) begin n_fail++; $display("FAIL bad_sum: got %h want 01", sum); end
    cpu_addr = 4'd0; #1;
    n_checks++; if (cpu_data !== 8'h09) begin n_fail++; $display("FAIL bad_read0: got %h want 09", cpu_data); end
  endtask

  task automatic test_stalled();
    logic [7:0] b;
    pulse_start();
    for (int i = 0; i < 17; i++) begin
      b = (i < 16) ? img[i] : 8'haa;
      bus.in_data  = b;
      bus.in_valid = 1'b1;
      tick();
      n_checks++; if (wr_addr !== 4'((i + 1) % 16) && i < 16) begin n_fail++; $display("FAIL stall_adv[%0d]: wr_addr=%h want %h", i, wr_addr, 4'((i + 1) % 16)); end
      bus.in_valid = 1'b0;
      bus.in_data  = 8'hff;
      tick();
      n_checks++; if (i < 16 && wr_addr !== 4'((i + 1) % 16)) begin n_fail++; $display("FAIL stall_hold[%0d]: wr_addr=%h want %h", i, wr_addr, 4'((i + 1) % 16)); end
    end
    n_checks++; if (done !== 1'b1 || cpu_hold !== 1'b0) begin n_fail++; $display("FAIL stall_done: done=%b hold=%b want 1 0", done, cpu_hold); end
    for (int a = 0; a < 16; a++) begin
      cpu_addr = 4'(a); #1;
      n_checks++; if (cpu_data !== img[a]) begin n_fail++; $display("FAIL stall_ram[%0d]: got %h want %h", a, cpu_data, img[a]); end
    end
  endtask

  task automatic test_reload();
    pulse_start();
    n_checks++; if (done !== 1'b0 || cpu_hold !== 1'b1 || wr_addr !== 4'd0) begin n_fail++; $display("FAIL reload_enter: done=%b hold=%b wr_addr=%h want 0 1 0", done, cpu_hold, wr_addr); end
    for (int i = 0; i < 5; i++) send_byte(8'h00);
    start = 1'b1;
    send_byte(8'h00);
    start = 1'b0;
    n_checks++; if (wr_addr !== 4'd6 || busy !== 1'b1) begin n_fail++; $display("FAIL reload_ignore_start: wr_addr=%h busy=%b want 6 1", wr_addr, busy); end
    for (int i = 6; i < 16; i++) send_byte(8'h00);
    send_byte(8'h00);
    n_checks++; if (done !== 1'b1 || cpu_hold !== 1'b0) begin n_fail++; $display("FAIL reload_done: done=%b hold=%b want 1 0", done, cpu_hold); end
    cpu_addr = 4'd3; #1;
    n_checks++; if (cpu_data !== 8'h00) begin n_fail++; $display("FAIL reload_read3: got %h want 00", cpu_data); end
  endtask

  task automatic test_reset_mid_load();
    pulse_start();
    for (int i = 0; i < 7; i++) send_byte(8'ha1 + 8'(i));
    clr = 1'b0;
    tick();
    clr = 1'b1;
    n_checks++; if (cpu_hold !== 1'b1 || busy !== 1'b0 || bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_state: hold=%b busy=%b ready=%b want 1 0 0", cpu_hold, busy, bus.in_ready); end
    n_checks++; if (wr_addr !== 4'd0 || sum !== 8'h00) begin n_fail++; $display("FAIL midrst_ctr: wr_addr=%h sum=%h want 0 00", wr_addr, sum); end
    for (int a = 0; a < 8; a++) begin
      cpu_addr = 4'(a); #1;
      n_checks++; if (cpu_data !== ((a < 7) ? 8'ha1 + 8'(a) : 8'h00)) begin n_fail++; $display("FAIL midrst_ram[%0d]: got %h want %h", a, cpu_data, (a < 7) ? 8'ha1 + 8'(a) : 8'h00); end
    end
  endtask

  initial begin
    clr          = 1'b0;
    start        = 1'b0;
    cpu_addr     = 4'd0;
    bus.in_data  = 8'h00;
    bus.in_valid = 1'b0;
    #1;
    test_reset();
    test_good_load();
    test_bad_checksum();
    test_stalled();
    test_reload();
    test_reset_mid_load();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
# prog_loader

Program loader and program memory for the 8-bit accumulator CPU. Accepts a 16-byte program plus checksum over a byte-wide valid/ready stream, writes it into an internal 16x8 program RAM, and holds the CPU in reset until a verified image is resident. The CPU fetches through a combinational read port, so this block is the writer at the other end of the CPU's instruction/data fetch path.

## Interface
- `DW`, 8, data/instruction width
- `AW`, 4, address width; depth = 2^AW = 16 words

- `clk` in 1 — system clock, rising edge
- `clr` in 1 — synchronous active-low reset
- `start` in 1 — single-cycle request to begin a load
- `in_data` in DW — program/checksum byte from host
- `in_valid` in 1 — `in_data` is valid
- `in_ready` out 1 — loader accepts a byte this cycle
- `cpu_addr` in AW — CPU fetch address (MAR)
- `cpu_data` out DW — RAM[`cpu_addr`], combinational
- `cpu_hold` out 1 — 1 = keep CPU in reset/halted
- `busy` out 1 — load in progress (LOAD or CHECK)
- `done` out 1 — verified image resident
- `err` out 1 — last load failed its checksum
- `wr_addr` out AW — next RAM address to be written
- `sum` out DW — running modulo-256 sum of accepted bytes

## Operation
- States: IDLE, LOAD, CHECK, DONE, ERR.
- IDLE/DONE/ERR + `start`=1 -> LOAD. On entry, clear `wr_addr` and `sum` to 0, and clear `done` and `err`.
- LOAD: `in_ready`=1. On each handshake (`in_valid` & `in_ready`):
  - write RAM[`wr_addr`] <= `in_data`
  - `sum` <= `sum` + `in_data` (mod 256)
  - increment `wr_addr`
- When the byte at `wr_addr`=15 is accepted, `wr_addr` wraps to 0 and the state moves to CHECK.
- CHECK: `in_ready`=1. The next accepted byte is the checksum and is not written to RAM.
  - (`sum` + byte) mod 256 == 0 -> DONE; otherwise -> ERR.
  - `sum` is updated to include the checksum byte.
- DONE: `done`=1 and `cpu_hold`=0. This is the only state with `cpu_hold`=0.
- ERR: `err`=1 and `cpu_hold`=1. RAM keeps the partial or bad image.
- `start` in LOAD or CHECK is ignored; a load cannot be restarted mid-stream except by `clr`.
- `start` and `in_valid` together in IDLE/DONE/ERR: only the state change happens. No byte is accepted, because `in_ready`=0 in those states.
- `cpu_data` always reflects RAM[`cpu_addr`], including during a load. The CPU is held, so this is harmless.
- RAM contents are not affected by `clr`.

## Timing
- Reset (`clr`=0 at a rising edge) gives: state IDLE, `wr_addr`=0, `sum`=0, `busy`=0, `done`=0, `err`=0, `cpu_hold`=1. `in_ready` is 0 after reset.
- Reset mid-load returns to IDLE, keeps whatever RAM was already written, and keeps `cpu_hold`=1.
- `start` sampled at edge N: state=LOAD and `in_ready`=1 from edge N onward, i.e. the first byte can be accepted at edge N+1.
- RAM write takes effect at the accepting edge. A CPU read of that address reflects the new data combinationally after that edge (zero-latency read).
- Minimum load time: 1 (start) + 16 (data) + 1 (checksum) = 18 edges. `done`/`cpu_hold` change on the checksum-accept edge.
- `in_ready` is a pure function of state (Moore), with no combinational path from `in_valid`.
- `in_valid` may deassert at any time. Gaps simply stall the load, and there is no timeout.

## Structure
- Shared package `loader_pkg`:
  - `DW`/`AW` defaults
  - state enum `ld_state_t` {IDLE, LOAD, CHECK, DONE, ERR}
  - `LD_DEPTH` = 16
- Sub-module `prog_ram`: 2^AW x DW memory with a synchronous write port (`we`, `waddr`, `wdata`) and an asynchronous read port (`raddr`, `rdata`), no reset.
- The top-level holds the FSM, counter and checksum.

## Test plan
- **Reset:** `clr`=0 for 2 cycles then 1 -> IDLE, `in_ready`=0, `cpu_hold`=1, `done`=`err`=0, `wr_addr`=0.
- **Good load:** `start`, then stream 09 1a 2b ec e0 f0 f0 00 00 10 14 18 20 00 00 00, then checksum AA.
  - During the load: `sum`=56 before the checksum.
  - After the checksum: `done`=1, `cpu_hold`=0, `sum`=00.
  - Readback: `cpu_addr`=3 -> `cpu_data`=ec; `cpu_addr`=12 -> `cpu_data`=20.
- **Bad checksum:** same 16 bytes, then checksum AB -> `err`=1, `done`=0, `cpu_hold`=1, RAM[0]=09.
- **Stalled stream:** `in_valid` toggles 1/0 each cycle during the good load -> same final RAM and `done`=1 after 34 data/checksum cycles. `wr_addr` advances only on handshakes.
- **Ignored start / reload:** `start` pulse at byte 5 of a load -> no effect. After DONE, `start` -> `done`=0, `cpu_hold`=1, `wr_addr`=0; reload of all-00 with checksum 00 -> DONE.
- **Reset mid-load:** `clr`=0 after 7 bytes -> IDLE, `cpu_hold`=1. RAM[0..6] keep the written values and RAM[7] keeps its prior value.
